// File: rtl/soc_system_led_driver.sv
// soc_system_led_driver: per-LED passthrough/PWM/blink/off shaping of PIO LED requests, Avalon-MM configured.
// Blink logic is built only when SOC_LED_DRIVER_BLINK_EN is defined; otherwise mode 10 is passthrough.
module soc_system_led_driver #(
  parameter int NUM_LEDS = 2,
  parameter int PWM_DIV  = 64,
  parameter int BLINK_W  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [2:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  input  logic [NUM_LEDS-1:0] led_in,
  output logic [NUM_LEDS-1:0] led_out
);
  localparam int PW = PWM_DIV > 1 ? $clog2(PWM_DIV) : 1;
  logic [PW-1:0] presc;
  logic tick, we, phase, blink_gate;
  logic [7:0] pwm_cnt;
  logic [2*NUM_LEDS-1:0] mode;
  logic [8*NUM_LEDS-1:0] duty;
  logic [NUM_LEDS-1:0] led_nxt;
  logic [31:0] bh_rd;
  assign we = chipselect && !write_n;
  assign tick = presc == PW'(PWM_DIV - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) pwm_cnt <= pwm_cnt + 8'd1;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mode <= '0;
      duty <= {NUM_LEDS{8'hFF}};
    end else if (we) begin
      if (address == 3'd0) mode <= writedata[2*NUM_LEDS-1:0];
      if (address == 3'd1) duty <= writedata[8*NUM_LEDS-1:0];
    end
`ifdef SOC_LED_DRIVER_BLINK_EN
  logic [BLINK_W-1:0] blink_half, blink_cnt;
  logic wrap;
  assign wrap = blink_cnt == blink_half;
  // A BLINK_HALF write restarts the half-period and overrides a coincident tick.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      blink_half <= BLINK_W'(1000);
      blink_cnt  <= '0;
      phase      <= 1'b0;
    end else if (we && address == 3'd2) begin
      blink_half <= writedata[BLINK_W-1:0];
      blink_cnt  <= '0;
    end else if (tick) begin
      blink_cnt <= wrap ? '0 : blink_cnt + BLINK_W'(1);
      phase     <= phase ^ wrap;
    end
  assign blink_gate = phase;
  assign bh_rd = 32'(blink_half);
`else
  assign phase = 1'b0;
  assign blink_gate = 1'b1;
  assign bh_rd = '0;
`endif
  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
    logic [1:0] m;
    logic [7:0] d;
    logic pwm_on;
    assign m = mode[2*i +: 2];
    assign d = duty[8*i +: 8];
    assign pwm_on = d == 8'hFF || pwm_cnt < d;
    assign led_nxt[i] = m == 2'd0 ? led_in[i] :
                        m == 2'd1 ? led_in[i] & pwm_on :
                        m == 2'd2 ? led_in[i] & blink_gate : 1'b0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) led_out <= '0;
    else led_out <= led_nxt;
  always_comb
    readdata = address == 3'd0 ? 32'(mode) :
               address == 3'd1 ? 32'(duty) :
               address == 3'd2 ? bh_rd :
               address == 3'd3 ? {23'd0, phase, 8'(led_out)} : '0;
endmodule

// File: doc/soc_system_led_driver.md
# soc_system_led_driver

Output stage placed between the LED PIO's 2-bit `out_port` and the board LED pins. Each LED's on/off request from the PIO is shaped by a per-LED mode: passthrough, PWM dimming, blinking, or forced off. Mode, duty and blink rate are configured through a small Avalon-MM slave on the same HPS-to-FPGA bus as the PIO. All LED outputs are registered.

## Interface

Parameters:
- `NUM_LEDS`, 2: LED count; 1..4.
- `PWM_DIV`, 64: clocks per PWM step (tick period); ≥1.
- `BLINK_W`, 16: blink half-period counter width; ≤24.

Ports:
- `clk` input 1: single clock domain for the whole block.
- `reset_n` input 1: asynchronous, active-low reset.
- `address` input 3: Avalon-MM word address.
- `chipselect` input 1: slave select.
- `write_n` input 1: active-low write.
- `writedata` input 32: write data.
- `readdata` output 32: combinational read data.
- `led_in` input NUM_LEDS: on/off requests from the PIO `out_port`, same clock domain.
- `led_out` output NUM_LEDS: registered LED pin drive, 1 = lit.

## Operation

- Write strobe: `chipselect && !write_n`. Registers update on the rising edge.
- Register map (word addresses):
  - 0 MODE: bits [2i+1:2i] select LED i mode.
    - 00 passthrough.
    - 01 PWM.
    - 10 blink.
    - 11 forced off.
  - 1 DUTY: bits [8i+7:8i] hold the 8-bit duty for LED i.
  - 2 BLINK_HALF: bits [BLINK_W-1:0].
  - 3 STATUS: read-only; [NUM_LEDS-1:0] = `led_out`, [8] = blink phase. Writes are ignored.
  - Addresses 4–7 read 0; writes to them are ignored.
  - Unused upper bits read 0.
- Register reset values:
  - MODE = 0.
  - DUTY = 0xFF in every lane.
  - BLINK_HALF = 1000.
- Tick prescaler:
  - `presc` counts 0..PWM_DIV-1 and wraps to 0.
  - `tick` is high in the cycle where `presc == PWM_DIV-1`.
  - With PWM_DIV = 1, `tick` is high every cycle.
- PWM:
  - 8-bit `pwm_cnt` increments on `tick` and wraps 255→0.
  - `pwm_on[i] = (duty_i == 0xFF) || (pwm_cnt < duty_i)`.
  - duty 0 is always off; 0xFF is always on.
- Blink:
  - `blink_cnt` increments on `tick`.
  - When a tick arrives with `blink_cnt == BLINK_HALF`, `blink_cnt` goes to 0 and `phase` toggles.
  - BLINK_HALF = 0 toggles `phase` on every tick.
- Next LED value per mode:
  - 00: `led_in[i]`.
  - 01: `led_in[i] & pwm_on[i]`.
  - 10: `led_in[i] & phase`.
  - 11: 0.
- `led_out` registers the next LED value every clock.
- Writing BLINK_HALF clears `blink_cnt` and leaves `phase` unchanged. This write wins over a coincident tick: no toggle, count = 0.
- Writing DUTY or MODE does not disturb any counter.

## Timing

- Reset (async assert, sync release via clk): `led_out`=0, `presc`=0, `pwm_cnt`=0, `blink_cnt`=0, `phase`=0, registers at reset values.
- `led_in` edge → `led_out`: 1 clock.
- Register write edge → `led_out` reflects the new configuration: 1 further clock (2 edges from the strobe).
- `readdata` is combinational from `address` and current state; zero wait states.
- PWM period = 256·PWM_DIV clocks.
- Blink half-period = (BLINK_HALF+1)·PWM_DIV clocks.
- Reset mid-operation: all state returns to reset values immediately. On release the prescaler restarts from 0.
- Counters run continuously regardless of mode and `led_in`.

## Configuration

- Macro `SOC_LED_DRIVER_BLINK_EN`.
- Defined: blink counter, `phase`, BLINK_HALF register and mode 10 behave as described above.
- Undefined:
  - Blink logic is absent.
  - Mode 10 behaves as passthrough.
  - Address 2 reads 0 and ignores writes.
  - STATUS[8] reads 0.

## Test plan

- Reset: assert `reset_n`=0 mid-run with `led_in`=2'b11 → `led_out`=0 immediately; after release, readback gives MODE 0x0, DUTY 0xFFFF, BLINK_HALF 1000, STATUS 0.
- Passthrough: MODE=0, drive `led_in` 00→10 → `led_out`=10 exactly one clock later; STATUS reads 0x2 the next cycle.
- PWM: PWM_DIV=4, MODE=0x1, DUTY lane0=64, `led_in`=01 → LED0 high 256 of every 1024 clocks, aligned to `pwm_cnt` wrap. DUTY=0 → constant 0; DUTY=0xFF → constant 1.
- Blink (macro defined): PWM_DIV=1, MODE=0x8 (LED1 blink), BLINK_HALF=3, `led_in`=10 → LED1 toggles every 4 clocks. Write BLINK_HALF=3 on a toggle cycle → toggle suppressed, next toggle 4 ticks later.
- Forced off / address decode: MODE=0xF with `led_in`=11 → `led_out`=00. Write to address 5 → no register changes; reads of addresses 4–7 return 0.
- Macro undefined: MODE=0x2, `led_in`=01 → LED0 follows `led_in` (passthrough); a write of 7 to address 2 reads back 0.
